// File: rtl/mux_rr_n_pkg.sv
// rtl/mux_rr_n_pkg.sv - shared constants and helpers for the mux_rr_n streaming selector
// Optional beat counter is enabled by defining MUX_CNT_EN.
package mux_rr_n_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_CH_NUM = 4;
   localparam int DEF_SEL_W  = 2;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// rtl/mux_rr_n_rr_arbiter.sv - rotating-priority arbiter, search starts at ptr and wraps
module rr_arbiter
   import mux_rr_n_pkg::*;
#(
   parameter int CH_NUM = DEF_CH_NUM,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic [CH_NUM-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [CH_NUM-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              any_grant
);

   int c;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      c         = 0;
      for (int off = 0; off < CH_NUM; off++) begin
         c = int'(ptr) + off;
         if (c >= CH_NUM) c = c - CH_NUM;
         if (!any_grant && req[c]) begin
            any_grant = 1'b1;
            grant_idx = SEL_W'(c);
            grant[c]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - N-channel registered stream mux, fixed-select or round-robin
// Define MUX_CNT_EN to add the saturating beat_cnt output.
module mux_rr_n
   import mux_rr_n_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CH_NUM = DEF_CH_NUM,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [CH_NUM*DATA_W-1:0] in_data,
   input  logic [CH_NUM-1:0]        in_valid,
   output logic [CH_NUM-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SEL_W-1:0]         out_ch
`ifdef MUX_CNT_EN
   ,
   output logic [CNT_W-1:0]         beat_cnt
`endif
);

   logic              load_en;
   logic [SEL_W-1:0]  rr_ptr;
   logic [CH_NUM-1:0] rr_grant;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_any;
   logic [CH_NUM-1:0] fix_grant;
   logic              fix_any;
   logic [CH_NUM-1:0] grant;
   logic [SEL_W-1:0]  g_idx;
   logic              g_any;
   logic [DATA_W-1:0] g_data;

   assign load_en = ~out_valid | out_ready;

   rr_arbiter #(
      .CH_NUM (CH_NUM),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .any_grant (rr_any)
   );

   // Compare against each legal index so an out-of-range sel simply matches nothing.
   always_comb begin
      fix_grant = '0;
      fix_any   = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (SEL_W'(i) == sel && in_valid[i]) begin
            fix_grant[i] = 1'b1;
            fix_any      = 1'b1;
         end
      end
   end

   assign grant = (mode == MODE_RR) ? rr_grant : fix_grant;
   assign g_any = (mode == MODE_RR) ? rr_any   : fix_any;
   assign g_idx = (mode == MODE_RR) ? rr_idx   : sel;

   always_comb begin
      g_data = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (grant[i]) g_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   assign in_ready = grant & {CH_NUM{load_en & rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (g_any) begin
            out_data  <= g_data;
            out_ch    <= g_idx;
            out_valid <= 1'b1;
            if (mode == MODE_RR)
               rr_ptr <= (rr_idx == SEL_W'(CH_NUM-1)) ? '0 : rr_idx + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (out_valid && out_ready && cnt_q != '1)
         cnt_q <= cnt_q + 1'b1;
   end

   assign beat_cnt = cnt_q;
`endif

endmodule
